// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared opcode constants and immediate-format selector for the decode stage
package id_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_sel_e;

endpackage

// File: rtl/id_imm_gen.sv
// rtl/id_imm_gen.sv - combinational RV32I immediate generator and opcode legality check
module id_imm_gen
  import id_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_sel_e        imm_sel,
  output logic            illegal_op
);

  logic [31:0] imm32;

  always_comb begin
    imm_sel    = IMM_NONE;
    illegal_op = 1'b0;
    case (instr[6:0])
      OP_IMM, LOAD, JALR, SYSTEM: imm_sel = IMM_I;
      STORE:                      imm_sel = IMM_S;
      BRANCH:                     imm_sel = IMM_B;
      LUI, AUIPC:                 imm_sel = IMM_U;
      JAL:                        imm_sel = IMM_J;
      OP:                         imm_sel = IMM_NONE;
      default:                    illegal_op = 1'b1;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (imm_sel)
      IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm32 = {instr[31:12], 12'b0};
      IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Every 32-bit form already carries instr[31] in its MSB, so widening sign-extends.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_decode_stage.sv
// rtl/id_decode_stage.sv - flow-controlled decode stage with register file; ID_WB_BYPASS_EN enables write-back capture bypass
module id_decode_stage
  import id_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int REG_AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc_out,
  output logic            illegal
);

  function automatic logic in_range(input logic [4:0] idx);
    return {27'b0, idx} < 32'(NREG);
  endfunction

  logic [XLEN-1:0] regs [NREG];
  logic [XLEN-1:0] imm_d;
  imm_sel_e        imm_sel;
  logic            illegal_op;
  logic [4:0]      rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0] rs1_rd, rs2_rd;
  logic            use_rd, use_rs1, use_rs2, illegal_d;
  logic            accept, wb_write;

  id_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr      (instr),
    .imm        (imm_d),
    .imm_sel    (imm_sel),
    .illegal_op (illegal_op)
  );

  assign rs1_idx  = instr[19:15];
  assign rs2_idx  = instr[24:20];
  assign rd_idx   = instr[11:7];
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign wb_write = wb_en && (wb_rd != 5'd0) && in_range(wb_rd);

  always_comb begin
    rs1_rd = (rs1_idx != 5'd0 && in_range(rs1_idx)) ? regs[rs1_idx[REG_AW-1:0]] : '0;
    rs2_rd = (rs2_idx != 5'd0 && in_range(rs2_idx)) ? regs[rs2_idx[REG_AW-1:0]] : '0;
`ifdef ID_WB_BYPASS_EN
    if (wb_en && wb_rd != 5'd0 && wb_rd == rs1_idx) rs1_rd = wb_data;
    if (wb_en && wb_rd != 5'd0 && wb_rd == rs2_idx) rs2_rd = wb_data;
`endif
  end

  // Field usage follows the format: S/B have no rd, U/J have no sources, only R/S/B read rs2.
  always_comb begin
    use_rd    = (imm_sel != IMM_S) && (imm_sel != IMM_B);
    use_rs1   = (imm_sel != IMM_U) && (imm_sel != IMM_J);
    use_rs2   = (imm_sel == IMM_NONE) || (imm_sel == IMM_S) || (imm_sel == IMM_B);
    illegal_d = illegal_op
              || (use_rd  && !in_range(rd_idx))
              || (use_rs1 && !in_range(rs1_idx))
              || (use_rs2 && !in_range(rs2_idx));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      rs1_data  <= '0;
      rs2_data  <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      opcode    <= '0;
      funct3    <= '0;
      funct7    <= '0;
      imm       <= '0;
      pc_out    <= '0;
      illegal   <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (wb_write) regs[wb_rd[REG_AW-1:0]] <= wb_data;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        rs1_data  <= rs1_rd;
        rs2_data  <= rs2_rd;
        rs1       <= rs1_idx;
        rs2       <= rs2_idx;
        rd        <= rd_idx;
        opcode    <= instr[6:0];
        funct3    <= instr[14:12];
        funct7    <= instr[31:25];
        imm       <= imm_d;
        pc_out    <= pc_in;
        illegal   <= illegal_d;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
